// File: rtl/duck_sprite_arbiter_pkg.sv
// rtl/duck_sprite_arbiter_pkg.sv - shared sprite geometry, address width and animation state type
// Package duck_pkg: no ports. Sprite frames are SPRITE_W x SPRITE_H words, stored back to back in the ROM.
package duck_pkg;
    localparam int SPRITE_W    = 68;
    localparam int SPRITE_H    = 64;
    localparam int FRAME_WORDS = 4352;
    localparam int N_FRAMES    = 4;
    localparam int ADDR_W      = 15;

    typedef enum logic {
        ANIM_RUN  = 1'b0,
        ANIM_HOLD = 1'b1
    } anim_state_e;
endpackage

// File: rtl/duck_sprite_arbiter_if.sv
// rtl/duck_sprite_arbiter_if.sv - sprite ROM port and pixel result bus of the duck sprite arbiter
// Signals: rom_address (to ROM), rom_q (palette index from ROM, read on the falling clock edge),
//          pix_valid / pix_index / pix_owner (pixel result).
// Modports: master = arbiter side, slave = ROM / pixel consumer side.
interface duck_sprite_arbiter_if;
    import duck_pkg::*;

    logic [ADDR_W-1:0] rom_address;
    logic [3:0]        rom_q;
    logic              pix_valid;
    logic [3:0]        pix_index;
    logic [1:0]        pix_owner;

    modport master (output rom_address, pix_valid, pix_index, pix_owner, input rom_q);
    modport slave  (input rom_address, pix_valid, pix_index, pix_owner, output rom_q);
endinterface

// File: rtl/duck_sprite_arbiter_hit_detect.sv
// rtl/duck_sprite_arbiter_hit_detect.sv - bounds check of one duck against the current pixel
// Ports: active_i (duck enable), draw_x_i/draw_y_i (pixel), duck_x_i/duck_y_i (duck top-left),
//        hit_o (pixel inside the duck), off_x_o/off_y_o (pixel offset inside the sprite, valid when hit_o).
module duck_hit_detect
    import duck_pkg::*;
(
    input  logic       active_i,
    input  logic [9:0] draw_x_i,
    input  logic [9:0] draw_y_i,
    input  logic [9:0] duck_x_i,
    input  logic [9:0] duck_y_i,
    output logic       hit_o,
    output logic [6:0] off_x_o,
    output logic [5:0] off_y_o
);
    logic [10:0] px, py, lx, ly;

    // One extra bit so duck_x + SPRITE_W past column 1023 cannot wrap back onto low columns.
    assign px = {1'b0, draw_x_i};
    assign py = {1'b0, draw_y_i};
    assign lx = {1'b0, duck_x_i};
    assign ly = {1'b0, duck_y_i};

    assign hit_o = active_i
                && (px >= lx) && (px < lx + 11'(SPRITE_W))
                && (py >= ly) && (py < ly + 11'(SPRITE_H));

    assign off_x_o = 7'(draw_x_i - duck_x_i);
    assign off_y_o = 6'(draw_y_i - duck_y_i);
endmodule

// File: rtl/duck_sprite_arbiter.sv
// rtl/duck_sprite_arbiter.sv - fixed-priority duck sprite arbiter with 2-stage ROM pipeline and animation FSM
// Ports: vga_clk, reset_n (sync, active low), DrawX/DrawY/blank (pixel), frame_start/anim_pause (animation),
//        duck_active/duck_x/duck_y/duck_dir (per duck), anim_frame (current frame), bus (ROM + pixel result).
// Optional feature: DUCK_MIRROR_EN enables horizontal mirroring for ducks with duck_dir set.
module duck_sprite_arbiter
    import duck_pkg::*;
#(
    parameter int N_DUCKS  = 4,
    parameter int ANIM_DIV = 8
) (
    input  logic                     vga_clk,
    input  logic                     reset_n,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic                     blank,
    input  logic                     frame_start,
    input  logic                     anim_pause,
    input  logic [N_DUCKS-1:0]       duck_active,
    input  logic [N_DUCKS-1:0][9:0]  duck_x,
    input  logic [N_DUCKS-1:0][9:0]  duck_y,
    input  logic [N_DUCKS-1:0]       duck_dir,
    output logic [1:0]               anim_frame,
    duck_sprite_arbiter_if.master    bus
);
    logic [N_DUCKS-1:0] hit;
    logic [6:0]         off_x [N_DUCKS];
    logic [5:0]         off_y [N_DUCKS];

    for (genvar g = 0; g < N_DUCKS; g++) begin : g_hit
        duck_hit_detect u_hit (
            .active_i (duck_active[g]),
            .draw_x_i (DrawX),
            .draw_y_i (DrawY),
            .duck_x_i (duck_x[g]),
            .duck_y_i (duck_y[g]),
            .hit_o    (hit[g]),
            .off_x_o  (off_x[g]),
            .off_y_o  (off_y[g])
        );
    end

    // Animation state
    anim_state_e state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [1:0]  anim_frame_q, anim_frame_d;

    // Pipeline state
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hit_q, blank_q;
    logic [1:0]        owner_q;
    logic              pix_valid_q, pix_valid_d;
    logic [3:0]        pix_index_q;
    logic [1:0]        pix_owner_q;

    logic       win_hit;
    logic [1:0] win_owner;
    logic [6:0] win_x, win_col;
    logic [5:0] win_y;

`ifdef DUCK_MIRROR_EN
    logic win_dir;
`else
    logic unused_dir;
    assign unused_dir = ^duck_dir;
`endif

    // Walk from the highest index down so the lowest hitting duck is the last, winning assignment.
    always_comb begin
        win_hit   = 1'b0;
        win_owner = '0;
        win_x     = '0;
        win_y     = '0;
`ifdef DUCK_MIRROR_EN
        win_dir   = 1'b0;
`endif
        for (int i = N_DUCKS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_hit   = 1'b1;
                win_owner = 2'(i);
                win_x     = off_x[i];
                win_y     = off_y[i];
`ifdef DUCK_MIRROR_EN
                win_dir   = duck_dir[i];
`endif
            end
        end
    end

`ifdef DUCK_MIRROR_EN
    assign win_col = win_dir ? (7'(SPRITE_W - 1) - win_x) : win_x;
`else
    assign win_col = win_x;
`endif

    assign addr_d = win_hit ? (ADDR_W'(anim_frame_q) * ADDR_W'(FRAME_WORDS)
                             + ADDR_W'(win_y) * ADDR_W'(SPRITE_W)
                             + ADDR_W'(win_col))
                            : '0;

    // rom_q already reflects addr_q: the ROM answered on the falling edge in between.
    assign pix_valid_d = hit_q && blank_q && (bus.rom_q != 4'd0);

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        anim_frame_d = anim_frame_q;
        if (frame_start) begin
            unique case (state_q)
                ANIM_RUN: begin
                    // Entering HOLD consumes this frame_start without counting it.
                    if (anim_pause) begin
                        state_d = ANIM_HOLD;
                    end else if (div_cnt_q == 8'(ANIM_DIV - 1)) begin
                        div_cnt_d    = '0;
                        anim_frame_d = anim_frame_q + 2'd1;
                    end else begin
                        div_cnt_d = div_cnt_q + 8'd1;
                    end
                end
                ANIM_HOLD: begin
                    if (!anim_pause) state_d = ANIM_RUN;
                end
                default: state_d = ANIM_RUN;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q      <= ANIM_RUN;
            div_cnt_q    <= '0;
            anim_frame_q <= '0;
            addr_q       <= '0;
            hit_q        <= 1'b0;
            blank_q      <= 1'b0;
            owner_q      <= '0;
            pix_valid_q  <= 1'b0;
            pix_index_q  <= '0;
            pix_owner_q  <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            anim_frame_q <= anim_frame_d;
            addr_q       <= addr_d;
            hit_q        <= win_hit;
            blank_q      <= blank;
            owner_q      <= win_owner;
            pix_valid_q  <= pix_valid_d;
            pix_index_q  <= pix_valid_d ? bus.rom_q : 4'd0;
            pix_owner_q  <= owner_q;
        end
    end

    assign bus.rom_address = addr_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_index   = pix_index_q;
    assign bus.pix_owner   = pix_owner_q;
    assign anim_frame      = anim_frame_q;
endmodule

// File: doc/duck_sprite_arbiter.md
DUCK_SPRITE_ARBITER -- requirements
Module: duck_sprite_arbiter

Interface
- REQ-001: Parameter N_DUCKS, default 4: number of duck requesters sharing one sprite ROM.
- REQ-002: Parameter ANIM_DIV, default 8: VGA frames per animation step, legal range 1..255.
- REQ-003: vga_clk  in  1  pixel clock; all logic is clocked on its rising edge.
- REQ-004: reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of vga_clk.
- REQ-005: DrawX, DrawY  in  10 each  current pixel coordinate.
- REQ-006: blank  in  1  high while the pixel is in the visible region.
- REQ-007: frame_start  in  1  one-cycle pulse at the start of each VGA frame.
- REQ-008: anim_pause  in  1  freezes animation while high.
- REQ-009: duck_active  in  N_DUCKS  per-duck enable.
- REQ-010: duck_x, duck_y  in  N_DUCKS x 10 each  top-left corner of each duck.
- REQ-011: duck_dir  in  N_DUCKS  1 means the duck faces left (mirrored sprite).
- REQ-012: rom_address  out  15  shared sprite ROM address; the ROM is read on ~vga_clk.
- REQ-013: rom_q  in  4  palette index returned by the ROM.
- REQ-014: pix_valid  out  1  a duck owns the pixel and the palette index is not transparent.
- REQ-015: pix_index  out  4  palette index for the pixel; 0 when pix_valid is 0.
- REQ-016: pix_owner  out  2  index of the winning duck.
- REQ-017: anim_frame  out  2  current animation frame.

Function
- REQ-018: A duck hits the pixel when duck_active[i], duck_x[i] <= DrawX < duck_x[i]+68, and duck_y[i] <= DrawY < duck_y[i]+64.
- REQ-019: Bounds comparisons use 11-bit arithmetic, so a duck near x=639 or y=479 never wraps to column 0 or row 0.
- REQ-020: Arbitration is fixed priority: the lowest-index hitting duck wins.
- REQ-021: Stage 1 (rising edge T) registers rom_address = anim_frame*4352 + (DrawY-duck_y)*68 + (DrawX-duck_x) for the winner, together with a hit flag, the owner and blank.
- REQ-022: With no hit, stage 1 registers rom_address = 0 and hit = 0.
- REQ-023: The ROM returns rom_q on the falling edge after T; stage 2 (rising edge T+1) registers pix_index, pix_valid and pix_owner, giving a fixed 2-cycle latency from DrawX/DrawY.
- REQ-024: pix_valid = stage-1 hit AND stage-1 blank AND rom_q != 0, so palette index 0 is transparent.
- REQ-025: Animation FSM states:
  - RUN: on frame_start, div_cnt increments; when it reaches ANIM_DIV-1, div_cnt clears and anim_frame increments mod 4 (3 wraps to 0).
  - HOLD: counters hold their values.
- REQ-026: FSM transitions: RUN->HOLD on a frame_start with anim_pause=1; HOLD->RUN on a frame_start with anim_pause=0. Pause changes therefore take effect only at frame boundaries.
- REQ-027: When frame_start coincides with the RUN->HOLD transition, that frame_start does not advance div_cnt.
- REQ-028: anim_frame changes only on a frame_start cycle and is sampled by stage 1 in the same cycle as the coordinates.

Reset
- REQ-029: While reset_n=0, every output and internal register is 0 and the FSM is in RUN: rom_address=0, pix_valid=0, pix_index=0, pix_owner=0, anim_frame=0, div_cnt=0.
- REQ-030: Reset asserted mid-frame or mid-pipeline flushes both stages; the first valid pixel appears 2 cycles after reset_n rises.

Configuration
- REQ-031: With DUCK_MIRROR_EN defined, a duck with duck_dir[i]=1 uses column 67-(DrawX-duck_x) in the address.
- REQ-032: Without DUCK_MIRROR_EN, duck_dir is ignored and no mirror logic is synthesised.

Structure
- REQ-033: Package duck_pkg holds SPRITE_W=68, SPRITE_H=64, FRAME_WORDS=4352, N_FRAMES=4, the animation FSM state enum, and the address width 15.
- REQ-034: Sub-module duck_hit_detect performs the per-duck bounds check and returns a hit bit plus the local x/y offset; it is instantiated N_DUCKS times.

Verification
- REQ-035: Duck0 at (100,50), anim_frame=0, DrawX=105, DrawY=52 -> rom_address=141 after 1 cycle; with rom_q=5, pix_valid=1, pix_index=5, pix_owner=0 after 2 cycles.
- REQ-036: Duck0 and duck2 both cover (120,60) -> pix_owner=0; with duck_active[0] cleared -> pix_owner=2.
- REQ-037: ANIM_DIV=2, 8 frame_start pulses -> anim_frame sequence 0,1,1,2,2,3,3,0 (wraps at 4); anim_pause held high for the next 3 pulses -> anim_frame unchanged.
- REQ-038: Duck at x=600, DrawX=5 -> no hit (no wrap); rom_q=0 inside a duck -> pix_valid=0, pix_index=0.
- REQ-039: DUCK_MIRROR_EN defined, duck_dir[0]=1, duck0 at (0,0), pixel (0,0) -> rom_address=67.
- REQ-040: reset_n pulled low mid-line for 1 cycle -> all outputs 0 on the next edge; anim_frame=0 thereafter.
